// File: rtl/ccm_ctr_sched_pkg.sv
// Shared definitions for the CCM counter-block scheduler: scheduler states
// and default widths/limits used by the top level and its arbiter.
package ccm_ctr_sched_pkg;

  localparam int WIDTH_COUNT_DEF     = 20;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int WIDTH_OUT_DEF       = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/ccm_ctr_sched_rr_arb2.sv
// Two-request round-robin arbiter. ptr names the stream granted last, so on
// a tie the other stream wins. Grants are only produced while advance is high.
module ccm_rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Pick at most one requester, preferring the one not served last.
  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      if (req == 2'b11) begin
        gnt = ptr ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/ccm_ctr_sched.sv
// Frame-level scheduler for the shared CCM counter-block generator. Loads
// per-stream block budgets, kills the generator at frame load, then issues
// blocks round-robin between two streams under an outstanding-credit limit.
module ccm_ctr_sched
  import ccm_ctr_sched_pkg::*;
#(
  parameter int WIDTH_COUNT     = WIDTH_COUNT_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int WIDTH_OUT       = WIDTH_OUT_DEF
) (
  input  logic                   clk,
  input  logic                   kill_n,
  input  logic                   frame_start,
  input  logic                   frame_abort,
  input  logic [WIDTH_COUNT-1:0] len0,
  input  logic [WIDTH_COUNT-1:0] len1,
  input  logic                   hold0,
  input  logic                   hold1,
  input  logic                   aes_ret,
  output logic                   ctr_kill,
  output logic                   ctr_ready,
  output logic                   ctr_stream_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_aborted,
  output logic                   err_start,
  output logic                   err_ret
);

  localparam logic [WIDTH_OUT-1:0]   MaxOut   = WIDTH_OUT'(MAX_OUTSTANDING);
  localparam logic [WIDTH_OUT-1:0]   OneOut   = WIDTH_OUT'(1);
  localparam logic [WIDTH_COUNT-1:0] OneCount = WIDTH_COUNT'(1);

  sched_state_e           state_q;
  logic [WIDTH_COUNT-1:0] rem0_q, rem0_d;
  logic [WIDTH_COUNT-1:0] rem1_q, rem1_d;
  logic [WIDTH_OUT-1:0]   out_q, out_d;
  logic                   ptr_q, ptr_d;
  logic                   err_ret_q, err_ret_d;

  logic       kill_q, ready_q, idx_q, busy_q, done_q, aborted_q, err_start_q;
  logic       credit_ok, advance, issue, start_ok, abort_run, ret_ok, ret_bad;
  logic [1:0] req, gnt;

  // Request qualification: a stream may be served only with budget left,
  // its consumer not stalled, and a credit free on the registered count.
  always_comb begin
    credit_ok = (out_q < MaxOut);
    start_ok  = (state_q == ST_IDLE) && frame_start;
    abort_run = (state_q == ST_RUN) && frame_abort;
    advance   = (state_q == ST_RUN) && !frame_abort;
    req[0]    = (rem0_q != '0) && !hold0 && credit_ok;
    req[1]    = (rem1_q != '0) && !hold1 && credit_ok;
  end

  ccm_rr_arb2 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .advance (advance),
    .gnt     (gnt)
  );

  // Next-state for budgets, credit count, round-robin pointer and the
  // sticky return error. A return with nothing outstanding is dropped.
  always_comb begin
    issue   = |gnt;
    ret_ok  = aes_ret && (out_q != '0);
    ret_bad = aes_ret && (out_q == '0);

    rem0_d = rem0_q;
    rem1_d = rem1_q;
    if (start_ok) begin
      rem0_d = len0;
      rem1_d = len1;
    end else if (abort_run) begin
      rem0_d = '0;
      rem1_d = '0;
    end else begin
      if (gnt[0]) rem0_d = rem0_q - OneCount;
      if (gnt[1]) rem1_d = rem1_q - OneCount;
    end

    out_d = out_q;
    if (issue && !ret_ok) begin
      out_d = out_q + OneOut;
    end else if (!issue && ret_ok) begin
      out_d = out_q - OneOut;
    end

    ptr_d     = issue ? gnt[1] : ptr_q;
    err_ret_d = (err_ret_q && !start_ok) || ret_bad;
  end

  // Datapath registers; pointer resets to stream 1 so stream 0 wins first.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      rem0_q    <= '0;
      rem1_q    <= '0;
      out_q     <= '0;
      ptr_q     <= 1'b1;
      err_ret_q <= 1'b0;
    end else begin
      rem0_q    <= rem0_d;
      rem1_q    <= rem1_d;
      out_q     <= out_d;
      ptr_q     <= ptr_d;
      err_ret_q <= err_ret_d;
    end
  end

  // Frame FSM with registered outputs; busy reflects the state being entered.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state_q     <= ST_IDLE;
      kill_q      <= 1'b0;
      ready_q     <= 1'b0;
      idx_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_start_q <= 1'b0;
    end else begin
      kill_q      <= 1'b0;
      ready_q     <= issue;
      idx_q       <= gnt[1];
      done_q      <= 1'b0;
      err_start_q <= frame_start && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          busy_q <= frame_start;
          if (frame_start) begin
            state_q   <= ST_LOAD;
            kill_q    <= 1'b1;
            aborted_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          busy_q  <= 1'b1;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          busy_q <= 1'b1;
          if (frame_abort) begin
            aborted_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if ((rem0_q == '0) && (rem1_q == '0)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          busy_q <= 1'b1;
          if (out_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctr_kill       = kill_q;
  assign ctr_ready      = ready_q;
  assign ctr_stream_idx = idx_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign frame_aborted  = aborted_q;
  assign err_start      = err_start_q;
  assign err_ret        = err_ret_q;

endmodule

// File: tb/tb_ccm_ctr_sched.sv
// Self-checking bench for ccm_ctr_sched: a hand-computed vector table for
// control corner cases, directed multi-cycle scenarios, and a randomized run,
// all compared cycle by cycle against a frame-level behavioural model.
module tb_ccm_ctr_sched;

  localparam int WC   = 20;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          kill_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_abort = 1'b0;
  logic [WC-1:0] len0 = '0;
  logic [WC-1:0] len1 = '0;
  logic          hold0 = 1'b0;
  logic          hold1 = 1'b0;
  logic          aes_ret = 1'b0;
  logic          ctr_kill, ctr_ready, ctr_stream_idx, busy;
  logic          frame_done, frame_aborted, err_start, err_ret;

  always #5 clk = ~clk;

  ccm_ctr_sched #(.WIDTH_COUNT(WC), .MAX_OUTSTANDING(MAXO), .WIDTH_OUT(3)) dut (
    .clk            (clk),
    .kill_n         (kill_n),
    .frame_start    (frame_start),
    .frame_abort    (frame_abort),
    .len0           (len0),
    .len1           (len1),
    .hold0          (hold0),
    .hold1          (hold1),
    .aes_ret        (aes_ret),
    .ctr_kill       (ctr_kill),
    .ctr_ready      (ctr_ready),
    .ctr_stream_idx (ctr_stream_idx),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_aborted  (frame_aborted),
    .err_start      (err_start),
    .err_ret        (err_ret)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural model: phase 0..4 = idle, load, run, drain, done.
  int mPhase, mOut, mLast;
  int mRem[2];
  bit mAborted, mErrRet;
  bit eReady, eIdx, eKill, eBusy, eDone, eErrStart;

  // Observations gathered by the directed scenarios.
  int       readyCount, doneCount;
  int       cnt[2];
  int       order[$];
  bit [3:0] readyHist;
  bit       autoRet;
  int       curLen0, curLen1;

  typedef struct {
    logic       st;
    logic       ret;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[13];

  // Record one comparison and report it if it disagrees.
  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] packOutputs();
    return {ctr_ready, ctr_ready & ctr_stream_idx, ctr_kill, busy,
            frame_done, frame_aborted, err_start, err_ret};
  endfunction

  function automatic void modelReset();
    mPhase = 0; mOut = 0; mLast = 1; mRem[0] = 0; mRem[1] = 0;
    mAborted = 0; mErrRet = 0;
    eReady = 0; eIdx = 0; eKill = 0; eBusy = 0; eDone = 0; eErrStart = 0;
    readyCount = 0; doneCount = 0; cnt[0] = 0; cnt[1] = 0;
    order.delete(); readyHist = '0;
  endfunction

  // Advance the model over one clock given the inputs held during that cycle.
  function automatic void modelStep(bit st, bit ab, int l0, int l1, bit h0, bit h1, bit ret);
    int nextPhase = mPhase;
    int grant = -1;
    int elig[$];
    eReady = 0; eKill = 0; eDone = 0;
    eErrStart = st && (mPhase != 0);
    case (mPhase)
      0: if (st) begin
        mRem[0] = l0; mRem[1] = l1; mAborted = 0; mErrRet = 0;
        eKill = 1; nextPhase = 1;
      end
      1: nextPhase = 2;
      2: if (ab) begin
        mRem[0] = 0; mRem[1] = 0; mAborted = 1; nextPhase = 3;
      end else begin
        if (mRem[0] == 0 && mRem[1] == 0) nextPhase = 3;
        if (mOut < MAXO) begin
          if (mRem[0] > 0 && !h0) elig.push_back(0);
          if (mRem[1] > 0 && !h1) elig.push_back(1);
        end
        if (elig.size() == 2) grant = 1 - mLast;
        else if (elig.size() == 1) grant = elig[0];
        if (grant >= 0) begin
          eReady = 1; eIdx = grant[0]; mRem[grant] = mRem[grant] - 1; mLast = grant;
        end
      end
      3: if (mOut == 0) begin
        nextPhase = 4; eDone = 1;
      end
      default: nextPhase = 0;
    endcase
    if (ret && mOut == 0) mErrRet = 1;
    mOut = mOut + ((grant >= 0) ? 1 : 0) - ((ret && mOut > 0) ? 1 : 0);
    mPhase = nextPhase;
    eBusy = (nextPhase != 0);
  endfunction

  function automatic logic [7:0] modelOutputs();
    return {eReady, eReady & eIdx, eKill, eBusy, eDone, mAborted, eErrStart, mErrRet};
  endfunction

  // Compare every output against the model just after the active edge.
  task automatic checkOutput();
    checkValue($sformatf("outputs@%0t", $time), 32'(packOutputs()), 32'(modelOutputs()));
  endtask

  // Drive one cycle of inputs, clock it, update the model and compare.
  task automatic applyStimulus(input bit st, input bit ab, input bit h0, input bit h1, input bit extraRet);
    bit ret;
    ret = (autoRet && readyHist[1]) || extraRet;
    frame_start = st; frame_abort = ab; hold0 = h0; hold1 = h1; aes_ret = ret;
    len0 = WC'(curLen0); len1 = WC'(curLen1);
    @(posedge clk);
    modelStep(st, ab, curLen0, curLen1, h0, h1, ret);
    #1;
    checkOutput();
    readyHist = {readyHist[2:0], ctr_ready};
    if (ctr_ready) begin
      readyCount++;
      cnt[ctr_stream_idx]++;
      order.push_back(int'(ctr_stream_idx));
    end
    if (frame_done) doneCount++;
  endtask

  // Table vectors are checked against hand-computed outputs only.
  task automatic applyVector(input int i);
    frame_start = tbl[i].st; aes_ret = tbl[i].ret; frame_abort = 0;
    hold0 = 0; hold1 = 0; len0 = '0; len1 = '0;
    @(posedge clk);
    #1;
    checkValue($sformatf("vector %0d", i), 32'(packOutputs()), 32'(tbl[i].exp));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    frame_start = 0; frame_abort = 0; hold0 = 0; hold1 = 0; aes_ret = 0;
    kill_n = 0;
    #1;
    checkValue("reset outputs", 32'(packOutputs()), 32'd0);
    #1;
    kill_n = 1;
    modelReset();
    autoRet = 0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int expOrder[5];
    expOrder = '{0, 1, 0, 1, 0};

    // {frame_start, aes_ret, {ready, idx, kill, busy, done, aborted, err_start, err_ret}}
    tbl[0]  = '{1'b0, 1'b0, 8'b00000000};
    tbl[1]  = '{1'b1, 1'b0, 8'b00110000};
    tbl[2]  = '{1'b0, 1'b0, 8'b00010000};
    tbl[3]  = '{1'b1, 1'b0, 8'b00010010};
    tbl[4]  = '{1'b0, 1'b0, 8'b00011000};
    tbl[5]  = '{1'b0, 1'b1, 8'b00000001};
    tbl[6]  = '{1'b0, 1'b0, 8'b00000001};
    tbl[7]  = '{1'b1, 1'b0, 8'b00110000};
    tbl[8]  = '{1'b0, 1'b0, 8'b00010000};
    tbl[9]  = '{1'b0, 1'b0, 8'b00010000};
    tbl[10] = '{1'b1, 1'b0, 8'b00011010};
    tbl[11] = '{1'b1, 1'b0, 8'b00000010};
    tbl[12] = '{1'b0, 1'b0, 8'b00000000};

    curLen0 = 0; curLen1 = 0;
    doReset();

    // Empty frames, busy-start errors and the sticky return error.
    for (int i = 0; i < 13; i++) applyVector(i);

    // Two streams, returns two cycles after each issue: strict alternation.
    doReset();
    curLen0 = 3; curLen1 = 2; autoRet = 1;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 60 && doneCount == 0; i++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t1 ready count", readyCount, 5);
    checkValue("t1 done count", doneCount, 1);
    if (order.size() == 5) begin
      for (int i = 0; i < 5; i++) checkValue($sformatf("t1 order %0d", i), order[i], expOrder[i]);
    end else begin
      checkValue("t1 order size", order.size(), 5);
    end

    // Credit limit: stall at four, each return frees one more issue.
    doReset();
    curLen0 = 8; curLen1 = 0;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t2 stall count", readyCount, 4);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t2 after one ret", readyCount, 5);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t2 issue with same-cycle ret", readyCount, 7);
    for (int i = 0; i < 40 && doneCount == 0; i++) applyStimulus(0, 0, 0, 0, mOut > 0);
    checkValue("t2 total issues", readyCount, 8);
    checkValue("t2 done count", doneCount, 1);

    // Stream 0 held: only stream 1 runs, then stream 0 after release.
    doReset();
    curLen0 = 100; curLen1 = 100; autoRet = 1;
    applyStimulus(1, 0, 1, 0, 0);
    for (int i = 0; i < 400 && cnt[1] < 100; i++) applyStimulus(0, 0, 1, 0, 0);
    checkValue("t4 stream1 issues", cnt[1], 100);
    checkValue("t4 stream0 while held", cnt[0], 0);
    for (int i = 0; i < 400 && doneCount == 0; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t4 stream0 issues", cnt[0], 100);
    checkValue("t4 done count", doneCount, 1);

    // Abort after three issues with two outstanding.
    doReset();
    curLen0 = 10; curLen1 = 10;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20 && readyCount < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    applyStimulus(0, 1, 1, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t5 no issue after abort", readyCount, 3);
    checkValue("t5 no done before returns", doneCount, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && doneCount == 0; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t5 done count", doneCount, 1);
    checkValue("t5 aborted flag", 32'(frame_aborted), 32'd1);

    // Asynchronous reset in the middle of a running frame.
    doReset();
    curLen0 = 50; curLen1 = 0; autoRet = 1;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0);
    checkValue("t6 running before kill", 32'(busy & ctr_ready), 32'd1);
    #1;
    kill_n = 0;
    #1;
    checkValue("t6 outputs after kill", 32'(packOutputs()), 32'd0);
    #1;
    kill_n = 1;
    modelReset();
    autoRet = 0;

    // Randomized frames against the model.
    for (int i = 0; i < 3000; i++) begin
      bit st, ab, h0, h1, ret;
      st  = ($urandom_range(0, 24) == 0);
      ab  = ($urandom_range(0, 79) == 0);
      h0  = ($urandom_range(0, 3) == 0);
      h1  = ($urandom_range(0, 3) == 0);
      ret = (mOut > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      if (st) begin
        curLen0 = $urandom_range(0, 10);
        curLen1 = $urandom_range(0, 10);
      end
      applyStimulus(st, ab, h0, h1, ret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
